beam_power_seq: RTL and testbench

// - Sequencer in front of the beam power calculator. Per-symbol RE stream control (vld/sop/eop)
//   in; RBG sideband out: RE index in RBG, RBG index, RBG load, symbol clear, measured-symbol flag.
// - Datapath integrator registers the beam data bus one stage so data aligns with these outputs.

---
 rtl/beam_power_seq_if.sv | 50 +++++
 rtl/beam_power_seq.sv | 194 +++++++++++++++++++
 tb/tb_beam_power_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/beam_power_seq_if.sv
// beam_power_seq_if
//   Groups the RE stream control, the per-symbol configuration and the RBG
//   sideband outputs of beam_power_seq.
//   master modport: the stream source/observer (drives i_*, reads o_*).
//   slave  modport: the sequencer itself (reads i_*, drives o_*).
//   Optional statistics signals exist only when BEAM_SEQ_STAT_EN is defined.
interface beam_power_seq_if #(
  parameter int PRB_W = 9
);
  logic [1:0]       i_rbg_size;
  logic [PRB_W-1:0] i_prb_num;
  logic [3:0]       i_meas_symb;
  logic [3:0]       i_symb_idx;
  logic             i_data_vld;
  logic             i_data_sop;
  logic             i_data_eop;
  logic             o_data_vld;
  logic             o_data_sop;
  logic             o_data_eop;
  logic             o_symb_clr;
  logic             o_symb_1st;
  logic [7:0]       o_re_num;
  logic [7:0]       o_rbg_num;
  logic             o_rbg_load;
  logic             o_len_err;
`ifdef BEAM_SEQ_STAT_EN
  logic [7:0]       o_rbg_cnt;
  logic [15:0]      o_symb_cnt;
`endif

  modport master (
    output i_rbg_size, i_prb_num, i_meas_symb, i_symb_idx,
    output i_data_vld, i_data_sop, i_data_eop,
    input  o_data_vld, o_data_sop, o_data_eop, o_symb_clr, o_symb_1st,
    input  o_re_num, o_rbg_num, o_rbg_load, o_len_err
`ifdef BEAM_SEQ_STAT_EN
    , input o_rbg_cnt, o_symb_cnt
`endif
  );

  modport slave (
    input  i_rbg_size, i_prb_num, i_meas_symb, i_symb_idx,
    input  i_data_vld, i_data_sop, i_data_eop,
    output o_data_vld, o_data_sop, o_data_eop, o_symb_clr, o_symb_1st,
    output o_re_num, o_rbg_num, o_rbg_load, o_len_err
`ifdef BEAM_SEQ_STAT_EN
    , output o_rbg_cnt, o_symb_cnt
`endif
  );
endinterface

// File: rtl/beam_power_seq.sv
// beam_power_seq
//   Sequencer in front of the beam power calculator. Follows the per-symbol
//   RE stream (vld/sop/eop) and produces the RBG sideband one cycle later:
//   RE index inside the RBG, RBG index, RBG load strobe, symbol clear,
//   measured-symbol flag and a sticky length/sequence error.
// Ports
//   i_clk   : data clock
//   i_reset : asynchronous reset, active-high
//   bus     : beam_power_seq_if.slave (config + stream in, sideband out)
// Optional feature
//   BEAM_SEQ_STAT_EN : adds o_rbg_cnt (RBGs in last symbol) and o_symb_cnt
//                      (accepted sops, wrapping) to the interface.
module beam_power_seq #(
  parameter int RE_PER_RB = 12,
  parameter int PRB_W     = 9
) (
  input  logic            i_clk,
  input  logic            i_reset,
  beam_power_seq_if.slave bus
);
  localparam int LEN_W = PRB_W + 4;  // holds PRB count * 12
  localparam logic [LEN_W:0] TOT_MAX = {(LEN_W + 1){1'b1}};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // REs per RBG for the encoded RBG size (10 and 11 both mean 16 RBs).
  function automatic logic [7:0] rbg_len_f(input logic [1:0] size);
    case (size)
      2'b00:   rbg_len_f = 8'(4 * RE_PER_RB);
      2'b01:   rbg_len_f = 8'(8 * RE_PER_RB);
      default: rbg_len_f = 8'(16 * RE_PER_RB);
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8_f(input logic [7:0] v);
    sat_inc8_f = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       cfg_size_q, cfg_size_d;
  logic [LEN_W-1:0] prb_len_q, prb_len_d;
  logic [LEN_W:0]   tot_q, tot_d;
  logic [7:0]       re_num_q, re_num_d;
  logic [7:0]       rbg_num_q, rbg_num_d;
  logic             rbg_load_q, rbg_load_d;
  logic             symb_clr_q, symb_clr_d;
  logic             symb_1st_q, symb_1st_d;
  logic             len_err_q, len_err_d;
  logic             data_vld_q, data_vld_d;
  logic             data_sop_q, data_sop_d;
  logic             data_eop_q, data_eop_d;
  logic             eop_acc_q, eop_acc_d;
  logic [LEN_W-1:0] prb_len_s;
  logic [LEN_W:0]   tot_inc_s;
`ifdef BEAM_SEQ_STAT_EN
  logic [7:0]       rbg_cnt_q, rbg_cnt_d;
  logic [15:0]      symb_cnt_q, symb_cnt_d;
`endif

  assign prb_len_s = LEN_W'(bus.i_prb_num) * LEN_W'(RE_PER_RB);
  // RE total saturates so a runaway symbol cannot wrap back under the limit.
  assign tot_inc_s = (tot_q == TOT_MAX) ? tot_q : tot_q + (LEN_W + 1)'(1);

  // Next-state, counter and sideband computation.
  always_comb begin
    state_d    = state_q;
    cfg_size_d = cfg_size_q;
    prb_len_d  = prb_len_q;
    tot_d      = tot_q;
    re_num_d   = re_num_q;
    rbg_num_d  = rbg_num_q;
    rbg_load_d = 1'b0;
    symb_clr_d = 1'b0;
    // The measured-symbol flag drops the cycle after the eop is presented.
    symb_1st_d = data_eop_q ? 1'b0 : symb_1st_q;
    len_err_d  = len_err_q;
    data_vld_d = bus.i_data_vld;
    data_sop_d = bus.i_data_vld & bus.i_data_sop;
    data_eop_d = bus.i_data_vld & bus.i_data_eop;
    eop_acc_d  = 1'b0;

    if (bus.i_data_vld && bus.i_data_sop) begin
      // Accepted sop (also restarts a symbol whose eop never came).
      state_d    = bus.i_data_eop ? ST_IDLE : ST_RUN;
      cfg_size_d = bus.i_rbg_size;
      prb_len_d  = prb_len_s;
      tot_d      = (LEN_W + 1)'(1);
      re_num_d   = 8'd0;
      rbg_num_d  = 8'd0;
      rbg_load_d = 1'b1;
      symb_clr_d = (bus.i_symb_idx == 4'd0);
      symb_1st_d = (bus.i_symb_idx == bus.i_meas_symb);
      eop_acc_d  = bus.i_data_eop;
      len_err_d  = (state_q == ST_RUN)
                 | (prb_len_s == {LEN_W{1'b0}})
                 | (bus.i_data_eop & (prb_len_s != LEN_W'(1)));
    end else if (bus.i_data_vld && (state_q == ST_RUN)) begin
      tot_d = tot_inc_s;
      if (re_num_q == rbg_len_f(cfg_size_q) - 8'd1) begin
        re_num_d   = 8'd0;
        rbg_num_d  = sat_inc8_f(rbg_num_q);
        rbg_load_d = 1'b1;
      end else begin
        re_num_d   = re_num_q + 8'd1;
      end
      if (tot_inc_s > {1'b0, prb_len_q}) begin
        len_err_d = 1'b1;
      end else begin
        len_err_d = len_err_q;
      end
      if (bus.i_data_eop) begin
        state_d   = ST_IDLE;
        eop_acc_d = 1'b1;
        if (tot_inc_s < {1'b0, prb_len_q}) begin
          len_err_d = 1'b1;
        end else begin
          len_err_d = len_err_d;
        end
      end else begin
        state_d = ST_RUN;
      end
    end else if (bus.i_data_vld) begin
      // Valid RE outside a symbol is dropped and flagged.
      len_err_d = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

`ifdef BEAM_SEQ_STAT_EN
  // Statistics: RBG count latched after an accepted eop, sop counter wraps.
  always_comb begin
    rbg_cnt_d  = eop_acc_q ? sat_inc8_f(rbg_num_q) : rbg_cnt_q;
    symb_cnt_d = (bus.i_data_vld && bus.i_data_sop) ? symb_cnt_q + 16'd1 : symb_cnt_q;
  end
`endif

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cfg_size_q <= 2'b00;
      prb_len_q  <= {LEN_W{1'b0}};
      tot_q      <= {(LEN_W + 1){1'b0}};
      re_num_q   <= 8'd0;
      rbg_num_q  <= 8'd0;
      rbg_load_q <= 1'b0;
      symb_clr_q <= 1'b0;
      symb_1st_q <= 1'b0;
      len_err_q  <= 1'b0;
      data_vld_q <= 1'b0;
      data_sop_q <= 1'b0;
      data_eop_q <= 1'b0;
      eop_acc_q  <= 1'b0;
`ifdef BEAM_SEQ_STAT_EN
      rbg_cnt_q  <= 8'd0;
      symb_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      cfg_size_q <= cfg_size_d;
      prb_len_q  <= prb_len_d;
      tot_q      <= tot_d;
      re_num_q   <= re_num_d;
      rbg_num_q  <= rbg_num_d;
      rbg_load_q <= rbg_load_d;
      symb_clr_q <= symb_clr_d;
      symb_1st_q <= symb_1st_d;
      len_err_q  <= len_err_d;
      data_vld_q <= data_vld_d;
      data_sop_q <= data_sop_d;
      data_eop_q <= data_eop_d;
      eop_acc_q  <= eop_acc_d;
`ifdef BEAM_SEQ_STAT_EN
      rbg_cnt_q  <= rbg_cnt_d;
      symb_cnt_q <= symb_cnt_d;
`endif
    end
  end

  assign bus.o_data_vld = data_vld_q;
  assign bus.o_data_sop = data_sop_q;
  assign bus.o_data_eop = data_eop_q;
  assign bus.o_symb_clr = symb_clr_q;
  assign bus.o_symb_1st = symb_1st_q;
  assign bus.o_re_num   = re_num_q;
  assign bus.o_rbg_num  = rbg_num_q;
  assign bus.o_rbg_load = rbg_load_q;
  assign bus.o_len_err  = len_err_q;
`ifdef BEAM_SEQ_STAT_EN
  assign bus.o_rbg_cnt  = rbg_cnt_q;
  assign bus.o_symb_cnt = symb_cnt_q;
`endif
endmodule

// File: tb/tb_beam_power_seq.sv
// Testbench for beam_power_seq: randomized RE streams, expected sideband
// computed from absolute RE position within the symbol, scoreboard queue
// drained by an independent monitor one cycle after each driven cycle.
module tb_beam_power_seq;
  logic i_clk;
  logic i_reset;

  beam_power_seq_if #(.PRB_W(9)) bus ();

  beam_power_seq #(.RE_PER_RB(12), .PRB_W(9)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        vld, sop, eop, clr, first, load, err;
    logic [7:0]  re, rbg, rbg_cnt;
    logic [15:0] symb_cnt;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Configuration presented on the bus (the model latches it at sop).
  int cfg_size, cfg_prb, cfg_idx, cfg_meas;

  // Reference model state: position-based, not counter-based.
  bit m_in_sym, m_first, m_err, m_prev_eop, m_pend;
  int m_pos, m_len, m_prb12, m_re, m_rbg, m_rbg_cnt, m_symb_cnt, m_pend_val;

  function automatic int rbg_res(int s);
    return 12 * ((s == 0) ? 4 : (s == 1) ? 8 : 16);
  endfunction

  function automatic int min255(int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_in_sym = 0; m_first = 0; m_err = 0; m_prev_eop = 0; m_pend = 0;
    m_pos = 0; m_len = 48; m_prb12 = 0; m_re = 0; m_rbg = 0;
    m_rbg_cnt = 0; m_symb_cnt = 0; m_pend_val = 0;
  endtask

  task automatic model_step(input bit vld, input bit sop, input bit eop, output exp_t e);
    bit load, clr;
    load = 0; clr = 0;
    if (m_pend) begin m_rbg_cnt = m_pend_val; m_pend = 0; end
    if (m_prev_eop) m_first = 0;
    if (vld && sop) begin
      m_len = rbg_res(cfg_size);
      m_prb12 = cfg_prb * 12;
      m_err = m_in_sym || (1 > m_prb12) || (eop && (1 < m_prb12));
      m_in_sym = !eop;
      m_pos = 0; m_re = 0; m_rbg = 0; load = 1;
      m_first = (cfg_idx == cfg_meas);
      clr = (cfg_idx == 0);
      m_symb_cnt = (m_symb_cnt + 1) % 65536;
      if (eop) begin m_pend = 1; m_pend_val = 1; end
    end else if (vld && m_in_sym) begin
      m_pos++;
      m_re = m_pos % m_len;
      m_rbg = min255(m_pos / m_len);
      load = (m_re == 0);
      if (m_pos + 1 > m_prb12) m_err = 1;
      if (eop) begin
        m_in_sym = 0;
        if (m_pos + 1 < m_prb12) m_err = 1;
        m_pend = 1;
        m_pend_val = min255(m_pos / m_len + 1);
      end
    end else if (vld) begin
      m_err = 1;
    end
    m_prev_eop = vld && eop;
    e.vld = vld; e.sop = vld && sop; e.eop = vld && eop;
    e.clr = clr; e.first = m_first; e.load = load; e.err = m_err;
    e.re = 8'(m_re); e.rbg = 8'(m_rbg);
    e.rbg_cnt = 8'(m_rbg_cnt); e.symb_cnt = 16'(m_symb_cnt);
  endtask

  // Drive one cycle of stream control; mid-symbol config is scrambled.
  task automatic drive(input bit vld, input bit sop, input bit eop);
    exp_t e;
    @(negedge i_clk);
    i_reset = 1'b0;
    bus.i_data_vld = vld;
    bus.i_data_sop = sop;
    bus.i_data_eop = eop;
    if (vld && sop) begin
      bus.i_rbg_size = 2'(cfg_size);
      bus.i_prb_num  = 9'(cfg_prb);
      bus.i_symb_idx = 4'(cfg_idx);
    end else begin
      bus.i_rbg_size = 2'($urandom_range(3));
      bus.i_prb_num  = 9'($urandom_range(511));
      bus.i_symb_idx = 4'($urandom_range(15));
    end
    bus.i_meas_symb = 4'(cfg_meas);
    model_step(vld, sop, eop, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_reset = 1'b1;
      bus.i_data_vld = 1'b0; bus.i_data_sop = 1'b0; bus.i_data_eop = 1'b0;
      model_reset();
      model_step(1'b0, 1'b0, 1'b0, e);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic send_symbol(input int size, input int prb, input int idx, input int meas,
                             input int nre, input int gap_pct, input bit with_eop);
    cfg_size = size; cfg_prb = prb; cfg_idx = idx; cfg_meas = meas;
    for (int i = 0; i < nre; i++) begin
      while (int'($urandom_range(99)) < gap_pct) idle_cycle();
      drive(1'b1, i == 0, with_eop && (i == nre - 1));
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    if (act !== expv) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  // Monitor: the DUT presents a result every cycle, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("data_vld", 16'(bus.o_data_vld), 16'(e.vld));
        chk("data_sop", 16'(bus.o_data_sop), 16'(e.sop));
        chk("data_eop", 16'(bus.o_data_eop), 16'(e.eop));
        chk("symb_clr", 16'(bus.o_symb_clr), 16'(e.clr));
        chk("symb_1st", 16'(bus.o_symb_1st), 16'(e.first));
        chk("rbg_load", 16'(bus.o_rbg_load), 16'(e.load));
        chk("len_err",  16'(bus.o_len_err),  16'(e.err));
        chk("re_num",   16'(bus.o_re_num),   16'(e.re));
        chk("rbg_num",  16'(bus.o_rbg_num),  16'(e.rbg));
`ifdef BEAM_SEQ_STAT_EN
        chk("rbg_cnt",  16'(bus.o_rbg_cnt),  16'(e.rbg_cnt));
        chk("symb_cnt", bus.o_symb_cnt,      e.symb_cnt);
`endif
      end
    end
  end

  initial begin
    int prb, nre, mode;
    i_reset = 1'b1;
    bus.i_data_vld = 1'b0; bus.i_data_sop = 1'b0; bus.i_data_eop = 1'b0;
    bus.i_rbg_size = 2'b00; bus.i_prb_num = 9'd0;
    bus.i_symb_idx = 4'd0; bus.i_meas_symb = 4'd0;
    cfg_size = 0; cfg_prb = 0; cfg_idx = 0; cfg_meas = 0;
    model_reset();
    do_reset(3);

    // Full 273-PRB symbol, 16-RB RBGs, contiguous.
    send_symbol(2, 273, 0, 0, 3276, 0, 1'b1);
    repeat (3) idle_cycle();
    // 4-RB RBGs with random gaps.
    send_symbol(0, 48, 5, 5, 576, 30, 1'b1);
    repeat (2) idle_cycle();
    // Non-zero, non-measured symbol index.
    send_symbol(1, 20, 3, 0, 240, 10, 1'b1);
    // Missing eop: new sop at RE 100.
    send_symbol(0, 30, 0, 0, 100, 0, 1'b0);
    send_symbol(0, 10, 0, 1, 120, 5, 1'b1);
    // Short symbol then single-RE symbol.
    send_symbol(3, 52, 2, 2, 600, 0, 1'b1);
    repeat (4) idle_cycle();
    send_symbol(1, 1, 0, 0, 1, 0, 1'b1);
    repeat (2) idle_cycle();
    // Stray valid REs and eop outside a symbol.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    // Over-length symbol.
    send_symbol(0, 2, 1, 1, 30, 0, 1'b1);
    // Reset in the middle of a symbol, then restart.
    send_symbol(1, 100, 0, 0, 500, 0, 1'b0);
    do_reset(2);
    send_symbol(1, 8, 0, 0, 96, 10, 1'b1);

    // Random symbols.
    for (int s = 0; s < 25; s++) begin
      prb = $urandom_range(1, 40);
      mode = $urandom_range(3);
      nre = (mode == 0) ? prb * 12 + $urandom_range(1, 20)
          : (mode == 1) ? $urandom_range(1, prb * 12) : prb * 12;
      send_symbol($urandom_range(3), prb, $urandom_range(3), $urandom_range(3),
                  nre, $urandom_range(40), ($urandom_range(7) != 0));
      repeat ($urandom_range(3)) idle_cycle();
    end
    repeat (3) idle_cycle();

    repeat (3) @(posedge i_clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
